// File: rtl/icache_pkg.sv
// Shared configuration for the direct-mapped instruction cache: geometry,
// derived address field widths, controller state encoding and field helpers.
package icache_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 16;

    localparam int WORD_SEL_W = $clog2(LINE_WORDS);
    localparam int OFFSET_W   = WORD_SEL_W + 2;
    localparam int INDEX_W    = $clog2(NUM_LINES);
    localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        COMPARE     = 3'd1,
        REFILL_REQ  = 3'd2,
        REFILL_DATA = 3'd3,
        RESPOND     = 3'd4
    } state_t;

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WORD_SEL_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the instruction cache: per-line valid bits (reset/flushable),
// tag RAM and data RAM with asynchronous read and single-word synchronous write.
module icache_array
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [WORD_SEL_W-1:0] rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [INST_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [WORD_SEL_W-1:0] wr_word,
    input  logic [INST_W-1:0]     wr_data,
    input  logic                  tag_wr,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  set_valid,
    input  logic                  clear_all
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [INST_W-1:0]    data_mem [NUM_LINES*LINE_WORDS];

    // Invalidate-all takes priority over marking a freshly filled line valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr) begin
            tag_mem[wr_index] <= wr_tag;
        end
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller with line refill.
// Defining ICACHE_PERF_EN adds saturating hit/miss performance counters.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wen_i,
    input  logic              flush_i,
    output logic              data_valid_o,
    output logic [INST_W-1:0] data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rdata_valid_i,
    input  logic [INST_W-1:0] mem_rdata_i
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit_cnt_o,
    output logic [31:0]       perf_miss_cnt_o
`endif
);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [WORD_SEL_W-1:0] cnt_q;
    logic                  flush_seen_q;
    logic [INST_W-1:0]     data_q;

    logic                  arr_valid;
    logic [TAG_W-1:0]      arr_tag;
    logic [INST_W-1:0]     arr_data;
    logic                  hit, accept_new, last_beat;
    logic                  load_addr, start_refill, wr_en, tag_wr, set_valid;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^addr_q[1:0];

    icache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (get_index(addr_q)),
        .rd_word   (get_word(addr_q)),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data),
        .wr_en     (wr_en),
        .wr_index  (get_index(addr_q)),
        .wr_word   (cnt_q),
        .wr_data   (mem_rdata_i),
        .tag_wr    (tag_wr),
        .wr_tag    (get_tag(addr_q)),
        .set_valid (set_valid),
        .clear_all (flush_i)
    );

    // A flush in the lookup cycle must not be masked by a stale valid bit.
    assign hit        = arr_valid && (arr_tag == get_tag(addr_q)) && !flush_i;
    assign accept_new = req_valid_i && !req_wen_i;
    assign last_beat  = mem_rdata_valid_i && (cnt_q == WORD_SEL_W'(LINE_WORDS - 1));

    always_comb begin
        state_d         = state_q;
        data_valid_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        load_addr       = 1'b0;
        start_refill    = 1'b0;
        wr_en           = 1'b0;
        tag_wr          = 1'b0;
        set_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_new) begin
                    load_addr = 1'b1;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    data_valid_o = 1'b1;
                    if (accept_new) begin
                        load_addr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    start_refill = 1'b1;
                    state_d      = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                if (mem_rdata_valid_i) begin
                    wr_en = 1'b1;
                    if (last_beat) begin
                        tag_wr    = 1'b1;
                        set_valid = !(flush_seen_q || flush_i);
                        state_d   = RESPOND;
                    end
                end
            end
            RESPOND: begin
                data_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // flush_seen_q remembers a fence.i that landed while the line was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q <= state_d;
            if (load_addr) begin
                addr_q <= req_addr_i;
            end
            if (start_refill) begin
                mem_addr_q   <= line_base(addr_q);
                cnt_q        <= '0;
                flush_seen_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (flush_i && (state_q == REFILL_REQ || state_q == REFILL_DATA)) begin
                    flush_seen_q <= 1'b1;
                end
            end
            if (data_valid_o) begin
                data_q <= arr_data;
            end
        end
    end

    assign data_o     = data_valid_o ? arr_data : data_q;
    assign mem_addr_o = mem_addr_q;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_cnt_o  <= '0;
            perf_miss_cnt_o <= '0;
        end else begin
            if (state_q == COMPARE && hit && perf_hit_cnt_o != 32'hFFFF_FFFF) begin
                perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
            end
            if (start_refill && perf_miss_cnt_o != 32'hFFFF_FFFF) begin
                perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a tag/valid model of the cache plus a backing
// memory function predict every response; a negedge monitor checks the outputs.
`timescale 1ns/1ps
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_wen_i, flush_i;
    logic [31:0] req_addr_i;
    logic        data_valid_o;
    logic [31:0] data_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_rdata_valid_i;
    logic [31:0] mem_rdata_i;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_cnt_o, perf_miss_cnt_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    logic [31:0] expLine = 32'h0;
    logic [31:0] lastData = 32'h0;
    bit          modelValid [16];
    logic [31:0] modelTag   [16];

    icache_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid_i),
        .req_addr_i        (req_addr_i),
        .req_wen_i         (req_wen_i),
        .flush_i           (flush_i),
        .data_valid_o      (data_valid_o),
        .data_o            (data_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_addr_o        (mem_addr_o),
        .mem_rdata_valid_i (mem_rdata_valid_i),
        .mem_rdata_i       (mem_rdata_i)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit_cnt_o    (perf_hit_cnt_o),
        .perf_miss_cnt_o   (perf_miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if ((a & 32'hFFFF_FFF0) == 32'h8000_0000)
            return 32'h11 * (((a >> 2) & 32'd3) + 32'd1);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) modelValid[i] = 1'b0;
    endtask

    // Monitor: every response must match the oldest outstanding prediction,
    // data_o must hold between responses, and refill addresses must be line-aligned.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_dv", 32'(data_valid_o), 32'd0);
            checkOutput("rst_data", data_o, 32'd0);
            checkOutput("rst_memreq", 32'(mem_req_valid_o), 32'd0);
            checkOutput("rst_memaddr", mem_addr_o, 32'd0);
            lastData = 32'h0;
        end else begin
            if (data_valid_o) begin
                if (expQ.size() == 0) checkOutput("spurious_dv", 32'd1, 32'd0);
                else checkOutput("resp_data", data_o, expQ.pop_front());
                lastData = data_o;
            end else begin
                checkOutput("data_hold", data_o, lastData);
            end
            if (mem_req_valid_o) checkOutput("mem_addr", mem_addr_o, expLine);
        end
    end

    // One fetch, hit or miss as the model predicts; gapBeat inserts an idle
    // cycle before that beat, flushBeat raises flush_i together with that beat.
    task automatic applyStimulus(input logic [31:0] addr, input int readyDelay,
                                 input int gapBeat, input int flushBeat);
        int          idx;
        logic [31:0] line;
        bit          hit;
        idx  = int'((addr >> 4) & 32'hF);
        line = addr & 32'hFFFF_FFF0;
        hit  = modelValid[idx] && (modelTag[idx] == (addr >> 8));
        expQ.push_back(memWord(addr));
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_wen_i   = 1'b0;
        @(negedge clk);
        if (hit) begin
            checkOutput("hit_latency", 32'(data_valid_o), 32'd1);
            checkOutput("hit_no_memreq", 32'(mem_req_valid_o), 32'd0);
            req_valid_i = 1'b0;
        end else begin
            checkOutput("miss_no_dv", 32'(data_valid_o), 32'd0);
            expLine = line;
            @(negedge clk);
            checkOutput("refill_req", 32'(mem_req_valid_o), 32'd1);
            for (int i = 0; i < readyDelay; i++) begin
                @(negedge clk);
                checkOutput("req_held", 32'(mem_req_valid_o), 32'd1);
            end
            mem_req_ready_i = 1'b1;
            @(negedge clk);
            mem_req_ready_i = 1'b0;
            checkOutput("req_dropped", 32'(mem_req_valid_o), 32'd0);
            for (int b = 0; b < 4; b++) begin
                if (b == gapBeat) begin
                    mem_rdata_valid_i = 1'b0;
                    @(negedge clk);
                end
                mem_rdata_valid_i = 1'b1;
                mem_rdata_i       = memWord(line + 32'(4 * b));
                flush_i           = (b == flushBeat);
                @(negedge clk);
                if (b < 3) checkOutput("no_early_dv", 32'(data_valid_o), 32'd0);
            end
            mem_rdata_valid_i = 1'b0;
            flush_i           = 1'b0;
            checkOutput("respond_dv", 32'(data_valid_o), 32'd1);
            req_valid_i = 1'b0;
            if (flushBeat >= 0) begin
                clearModel();
            end else begin
                modelValid[idx] = 1'b1;
                modelTag[idx]   = addr >> 8;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_addr_i = 32'h0; req_wen_i = 1'b0; flush_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_rdata_valid_i = 1'b0; mem_rdata_i = 32'h0;
        clearModel();
        for (int i = 0; i < 16; i++) modelTag[i] = 32'h0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Test 1: cold miss and refill
        applyStimulus(32'h8000_0000, 0, -1, -1);
        checkOutput("t1_data_lit", data_o, 32'h11);
        checkOutput("t1_memaddr_lit", mem_addr_o, 32'h8000_0000);
        @(negedge clk);

        // Test 2: back-to-back hits on the rest of the line
        req_valid_i = 1'b1;
        req_wen_i   = 1'b0;
        for (int i = 1; i < 4; i++) begin
            req_addr_i = 32'h8000_0000 + 32'(4 * i);
            expQ.push_back(memWord(req_addr_i));
            @(negedge clk);
            checkOutput("burst_dv", 32'(data_valid_o), 32'd1);
            checkOutput("burst_lit", data_o, 32'h11 * 32'(i + 1));
            checkOutput("burst_no_memreq", 32'(mem_req_valid_o), 32'd0);
        end
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("burst_end", 32'(data_valid_o), 32'd0);
`ifdef ICACHE_PERF_EN
        checkOutput("perf_miss", perf_miss_cnt_o, 32'd1);
        checkOutput("perf_hit", perf_hit_cnt_o, 32'd3);
`endif

        // Test 3: conflict eviction in index 0
        applyStimulus(32'h8000_0100, 0, -1, -1);
        @(negedge clk);
        applyStimulus(32'h8000_0000, 0, -1, -1);
        checkOutput("t3_data_lit", data_o, 32'h11);
        @(negedge clk);

        // Test 4: memory stalls the request, then a gap between beats
        applyStimulus(32'h8000_0244, 5, 2, -1);
        checkOutput("t4_data_lit", data_o, 32'hDA5A_0D4B);
        @(negedge clk);
        applyStimulus(32'h8000_0248, 0, -1, -1);
        @(negedge clk);

        // Write requests are dropped even for a cached address
        req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = 32'h8000_0244;
        repeat (3) begin
            @(negedge clk);
            checkOutput("wen_no_dv", 32'(data_valid_o), 32'd0);
            checkOutput("wen_no_memreq", 32'(mem_req_valid_o), 32'd0);
        end
        req_valid_i = 1'b0; req_wen_i = 1'b0;
        @(negedge clk);

        // Test 5: flush mid-refill, and flush on the final beat
        applyStimulus(32'h8000_0384, 0, -1, 1);
        @(negedge clk);
        applyStimulus(32'h8000_0384, 0, -1, 3);
        @(negedge clk);
        applyStimulus(32'h8000_0384, 1, -1, -1);
        @(negedge clk);
        applyStimulus(32'h8000_038C, 0, -1, -1);
        @(negedge clk);

        // Test 6: asynchronous reset during a refill
        req_valid_i = 1'b1; req_addr_i = 32'h8000_05C0; expLine = 32'h8000_05C0;
        @(negedge clk);
        @(negedge clk);
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rdata_valid_i = 1'b1;
            mem_rdata_i = memWord(32'h8000_05C0 + 32'(4 * b));
            @(negedge clk);
        end
        mem_rdata_valid_i = 1'b0;
        req_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_memreq", 32'(mem_req_valid_o), 32'd0);
        checkOutput("async_rst_data", data_o, 32'd0);
        checkOutput("async_rst_memaddr", mem_addr_o, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        clearModel();
        @(negedge clk);
        applyStimulus(32'h8000_0384, 0, -1, -1);
        @(negedge clk);
        applyStimulus(32'h8000_0380, 0, -1, -1);
        @(negedge clk);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the pipeline's fetch (PC/IF_ID) stage.
- Front side: consumes the PC fetch request (address, request valid, write enable); returns instruction word plus data-valid, which CTRL uses to stall.
- Back side: refills whole lines from a slower memory bus, one word per beat.

Parameters:
ADDR_W, 32, fetch/memory address width
INST_W, 32, instruction word width
LINE_WORDS, 4, words per line (power of 2, >=2)
NUM_LINES, 16, number of lines (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid_i  in  1  core fetch request; held stable with req_addr_i until data_valid_o
req_addr_i  in  ADDR_W  fetch address; bits [1:0] ignored
req_wen_i  in  1  write request; cache is read-only, request with wen=1 is dropped
flush_i  in  1  invalidate all lines (fence.i)
data_valid_o  out  1  instruction valid, 1-cycle pulse per accepted request
data_o  out  INST_W  instruction word
mem_req_valid_o  out  1  line-refill request
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  ADDR_W  line-aligned refill address
mem_rdata_valid_i  in  1  refill beat valid
mem_rdata_i  in  INST_W  refill beat data, ascending word order

Behaviour:
- Address split: offset = log2(LINE_WORDS)+2 bits; index = log2(NUM_LINES) bits; tag = remaining bits.
- Reset (async, any state): state=IDLE; all valid bits 0; data_valid_o=0, data_o=0, mem_req_valid_o=0, mem_addr_o=0; beat counter 0. Data/tag arrays are not reset.
- IDLE:
  - req_valid_i & !req_wen_i: register address, go COMPARE.
  - req_wen_i=1: request ignored; no response.
- COMPARE:
  - Hit (valid & tag match): data_valid_o=1 and data_o=word in this cycle, i.e. 1 cycle after acceptance.
  - Hit with a new req_valid_i present in the same cycle: accept it, stay in COMPARE. Back-to-back hits sustain 1 instruction/cycle.
  - Miss: go REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid_o=1; mem_addr_o = registered address with offset bits zeroed.
  - Both held stable until mem_req_ready_i=1; then go REFILL_DATA, counter=0.
- REFILL_DATA:
  - Each mem_rdata_valid_i beat writes word[counter] and increments the counter.
  - Beats without valid are waited on indefinitely.
  - On beat LINE_WORDS-1: write tag, set valid, go RESPOND.
- RESPOND: data_valid_o=1, data_o = requested word from the filled line; go IDLE.
- No new request is accepted in REFILL_REQ, REFILL_DATA or RESPOND; the core stalls via data_valid_o=0.
- The response is always for the captured address, even if req_addr_i changes (branch redirect). CTRL discards stale responses.
- data_o holds its last value when data_valid_o=0.
- flush_i:
  - Clears all valid bits at the next edge.
  - If flush_i is high in COMPARE, the lookup treats the array as invalid (miss).
  - If flush_i is high at any point during REFILL_REQ/REFILL_DATA, the line is filled but not marked valid; RESPOND still occurs.
- Simultaneous flush_i and final refill beat: flush wins, valid stays 0.
- Wrap-around: addresses differing only in tag map to the same index; the newest refill evicts.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined: adds outputs perf_hit_cnt_o and perf_miss_cnt_o, each 32-bit.
  - hit increments on each COMPARE hit; miss increments on each COMPARE->REFILL_REQ.
  - Both are reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg:
  - FSM state encoding (IDLE, COMPARE, REFILL_REQ, REFILL_DATA, RESPOND).
  - Derived widths: OFFSET_W, INDEX_W, TAG_W.
  - Field-extract helper functions.
- Sub-module icache_array: valid bits, tag RAM, data RAM.
  - Asynchronous read.
  - Synchronous word write with line-valid set/clear-all.

Test Plan:
1. Reset; req 0x80000000 -> mem_req_valid_o=1, mem_addr_o=0x80000000; beats 0x11,0x22,0x33,0x44 -> data_valid_o 1 cycle after 4th beat, data_o=0x11.
2. After test 1, back-to-back requests 0x80000004, 0x80000008, 0x8000000C -> data_valid_o on 3 consecutive cycles, data_o 0x22, 0x33, 0x44, no mem_req_valid_o.
3. Conflict: 0x80000100 (same index 0) -> miss, refill, then 0x80000000 -> misses again.
4. Hold mem_req_ready_i=0 for 5 cycles -> mem_req_valid_o=1 and mem_addr_o unchanged for all 5 cycles; refill starts only after ready.
5. flush_i during REFILL_DATA -> response delivered; immediate re-request of the same address misses. req_wen_i=1 -> no data_valid_o, no mem request.
6. Assert rst mid-REFILL_DATA -> all outputs 0 immediately; the next request to the previously cached line misses. With ICACHE_PERF_EN, tests 1–2 give perf_miss_cnt_o=1, perf_hit_cnt_o=3.
